// File: rtl/hgp_mod_addsub_pipe_pkg.sv
// Shared constants for the modulo-(2^WIDTH-1) add/sub pipeline: legal width range,
// pipeline depth and operation encodings.
package hgp_mod_addsub_pipe_pkg;

    localparam int WIDTH_MIN   = 2;
    localparam int WIDTH_MAX   = 32;
    localparam int STAGE_COUNT = 3;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/hgp_bit_cell.sv
// Per-bit half-sum / generate / propagate cell used by stage 1 of the
// modulo add/sub pipeline.
module hgp_bit_cell (
    input  logic a,
    input  logic b,
    output logic h,
    output logic g,
    output logic p
);

    assign h = a ^ b;
    assign g = a & b;
    assign p = a | b;

endmodule

// File: rtl/hgp_mod_addsub_pipe.sv
// 3-stage pipelined modulo-(2^WIDTH-1) adder/subtractor with valid/ready handshake.
// Define HGP_ZERO_NORMALISE_EN to map the all-ones (negative zero) result to all-zeros.
module hgp_mod_addsub_pipe
    import hgp_mod_addsub_pipe_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_s,
    output logic             out_zero
);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("hgp_mod_addsub_pipe: WIDTH out of range 2..32");
    end

    // The whole pipe advances as one unit; a full output register blocks everything.
    logic en;
    assign en       = ~out_valid | out_ready;
    assign in_ready = en;

    // Stage 1: subtraction is addition of the one's complement of B.
    logic [WIDTH-1:0] b_op, h_c, g_c, p_c;
    assign b_op = (in_sub == OP_SUB) ? ~in_b : in_b;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        hgp_bit_cell u_cell (
            .a (in_a[i]),
            .b (b_op[i]),
            .h (h_c[i]),
            .g (g_c[i]),
            .p (p_c[i])
        );
    end

    logic             v1;
    logic [WIDTH-1:0] h1, g1, p1;

    // NOTE: state uses non-blocking assignments and async reset so every stage
    // updates from the previous cycle's values regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            h1 <= '0;
            g1 <= '0;
            p1 <= '0;
        end else if (en) begin
            v1 <= in_valid;
            h1 <= h_c;
            g1 <= g_c;
            p1 <= p_c;
        end
    end

    // Stage 2: serial prefix; the top group propagate is never consumed downstream.
    logic [WIDTH-1:0] gg_c;
    logic [WIDTH-2:0] pp_c;

    // NOTE: every combinational output gets a default first so no latch can be inferred.
    always_comb begin
        gg_c    = '0;
        pp_c    = '0;
        gg_c[0] = g1[0];
        pp_c[0] = p1[0];
        for (int i = 1; i < WIDTH; i++) begin
            gg_c[i] = g1[i] | (p1[i] & gg_c[i-1]);
        end
        for (int i = 1; i < WIDTH - 1; i++) begin
            pp_c[i] = p1[i] & pp_c[i-1];
        end
    end

    logic             v2, cout2;
    logic [WIDTH-1:0] h2;
    logic [WIDTH-2:0] gg2, pp2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2    <= 1'b0;
            h2    <= '0;
            gg2   <= '0;
            pp2   <= '0;
            cout2 <= 1'b0;
        end else if (en) begin
            v2    <= v1;
            h2    <= h1;
            gg2   <= gg_c[WIDTH-2:0];
            pp2   <= pp_c;
            cout2 <= gg_c[WIDTH-1];
        end
    end

    // Stage 3: end-around carry re-enters at bit 0; one pass always suffices.
    logic [WIDTH-1:0] carry, sum_c, sum_n;
    logic             zero_c;

    assign carry = {gg2 | (pp2 & {(WIDTH-1){cout2}}), cout2};
    assign sum_c = h2 ^ carry;

`ifdef HGP_ZERO_NORMALISE_EN
    assign sum_n  = (&sum_c) ? '0 : sum_c;
    assign zero_c = (sum_n == '0);
`else
    assign sum_n  = sum_c;
    assign zero_c = (sum_c == '0) | (&sum_c);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_s     <= '0;
            out_zero  <= 1'b0;
        end else if (en) begin
            out_valid <= v2;
            out_s     <= sum_n;
            out_zero  <= zero_c;
        end
    end

endmodule

// File: tb/tb_hgp_mod_addsub_pipe.sv
// Self-checking bench for hgp_mod_addsub_pipe at WIDTH=4 (M=15): directed vectors,
// latency, backpressure and mid-flight reset, with a reference model scoreboard.
module tb_hgp_mod_addsub_pipe;

    localparam int W = 4;

    logic         clk, rst_n;
    logic         in_valid, in_ready, in_sub;
    logic [W-1:0] in_a, in_b, out_s;
    logic         out_valid, out_ready, out_zero;

    hgp_mod_addsub_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_s     (out_s),
        .out_zero  (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int n_in   = 0;
    int n_out  = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    typedef struct {
        logic [W-1:0] s;
        logic         z;
    } exp_t;

    // Reference: plain integer arithmetic modulo 15 with the hardware's zero encoding.
    function automatic exp_t model(input int a, input int b, input bit sub);
        exp_t e;
        int   bb, t;
        bb = sub ? (15 - b) : b;
        t  = a + bb;
        if (t > 15) t = t - 15;
        e.z = (t == 0) || (t == 15);
`ifdef HGP_ZERO_NORMALISE_EN
        if (t == 15) t = 0;
`endif
        e.s = t[W-1:0];
        return e;
    endfunction

    exp_t q[$];

    // Inputs change just after posedge, so negedge values are what the next edge sees.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            if (in_valid && in_ready) begin
                q.push_back(model(int'(in_a), int'(in_b), in_sub));
                n_in++;
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (q.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("model_s", out_s, e.s);
                    check("model_zero", out_zero, e.z);
                end
            end
        end
    end

    // Called just after a posedge; returns just after the edge that accepted the beat.
    task automatic send(input int a, input int b, input bit sub);
        bit acc;
        acc      = 1'b0;
        in_a     = a[W-1:0];
        in_b     = b[W-1:0];
        in_sub   = sub;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) check("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_out();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = out_valid;
        end
        if (!seen) check("out_timeout", 0, 1);
    endtask

    task automatic directed(input string name, input int a, input int b, input bit sub,
                            input int exp_s, input bit exp_z);
        send(a, b, sub);
        wait_out();
        check({name, "_s"}, out_s, exp_s);
        check({name, "_zero"}, out_zero, exp_z);
        @(posedge clk);
        #1;
    endtask

`ifdef HGP_ZERO_NORMALISE_EN
    localparam int NEG_ZERO = 0;
`else
    localparam int NEG_ZERO = 15;
`endif

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_sub    = 1'b0;
        out_ready = 1'b1;

        @(negedge clk);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_s", out_s, 0);
        check("reset_out_zero", out_zero, 0);
        check("reset_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Latency: 5+7 appears exactly three edges after acceptance.
        in_a = 4'd5; in_b = 4'd7; in_sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        check("lat_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("lat_valid_1", out_valid, 0);
        @(negedge clk);
        check("lat_valid_2", out_valid, 0);
        @(negedge clk);
        check("lat_valid_3", out_valid, 1);
        check("add_5_7_s", out_s, 12);
        check("add_5_7_zero", out_zero, 0);
        @(posedge clk);
        #1;

        directed("add_9_8",   9,  8, 1'b0, 2,  1'b0);
        directed("add_8_8",   8,  8, 1'b0, 1,  1'b0);
        directed("sub_3_5",   3,  5, 1'b1, 13, 1'b0);
        directed("sub_5_3",   5,  3, 1'b1, 2,  1'b0);
        directed("sub_7_7",   7,  7, 1'b1, NEG_ZERO, 1'b1);
        directed("add_15_0", 15,  0, 1'b0, NEG_ZERO, 1'b1);
        directed("add_15_15",15, 15, 1'b0, NEG_ZERO, 1'b1);
        directed("add_0_0",   0,  0, 1'b0, 0,  1'b1);
        directed("sub_15_0", 15,  0, 1'b1, NEG_ZERO, 1'b1);

        // Back-to-back stream at full throughput.
        send(1, 2, 1'b0);
        send(12, 11, 1'b1);
        send(4, 13, 1'b0);
        wait_out();
        repeat (6) @(negedge clk);
        check("stream_drained", q.size(), 0);

        // Backpressure: output held for 5 cycles while a 4-beat stream pushes in.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        fork
            begin
                send(1, 2, 1'b0);
                send(6, 9, 1'b0);
                send(10, 4, 1'b1);
                send(14, 3, 1'b0);
            end
            begin
                logic [W-1:0] held;
                wait_out();
                held = out_s;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    check("bp_in_ready", in_ready, 0);
                    check("bp_out_valid", out_valid, 1);
                    check("bp_out_s", out_s, held);
                end
                check("bp_first_s", held, 3);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        repeat (8) @(negedge clk);
        check("bp_queue_empty", q.size(), 0);
        check("bp_in_eq_out", n_out, n_in);

        // Reset with two beats in flight.
        @(posedge clk);
        #1;
        send(2, 3, 1'b0);
        send(4, 5, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", out_valid, 0);
        check("rst_async_s", out_s, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("rst_no_output", out_valid, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
